video_timing_gen: RTL and testbench

VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

---
 rtl/video_timing_gen.sv | 216 +++++++++++++++++++++
 tb/tb_video_timing_gen.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_timing_gen.sv
// Raster timing generator: pixel/line counters, polarity-applied syncs, active-display, new-frame pulse, frame count.
// Latency: counters, nf_out, fc_out, cfg_err_out registered (1 cycle); ad_out, hs_out, vs_out, cfg_ready_out combinational.
// Backpressure: cfg_ready_out drops while one timing set waits for the frame wrap; rejected sets leave it high.
//
// Ports:
//   pixel_clk_in, rst_in              clock and synchronous active-high reset
//   cfg_valid_in / cfg_ready_out      timing-set handshake
//   cfg_*_in                          horizontal/vertical field values and sync polarities
//   hcount_out, vcount_out            pixel and line index
//   hs_out, vs_out, ad_out            syncs (polarity applied) and active-display flag
//   nf_out, fc_out                    new-frame pulse and frame count modulo FPS
//   cfg_err_out                       one-cycle pulse for a rejected timing set
module video_timing_gen #(
    parameter int H_W      = 12,
    parameter int V_W      = 11,
    parameter int FPS      = 60,
    parameter int FC_W     = 6,
    parameter int DEF_HA   = 1280,
    parameter int DEF_HFP  = 110,
    parameter int DEF_HS   = 40,
    parameter int DEF_HBP  = 220,
    parameter int DEF_VA   = 720,
    parameter int DEF_VFP  = 5,
    parameter int DEF_VS   = 5,
    parameter int DEF_VBP  = 20,
    parameter bit DEF_HPOL = 1'b1,
    parameter bit DEF_VPOL = 1'b1
) (
    input  logic            pixel_clk_in,
    input  logic            rst_in,
    input  logic            cfg_valid_in,
    output logic            cfg_ready_out,
    input  logic [H_W-1:0]  cfg_ha_in,
    input  logic [H_W-1:0]  cfg_hfp_in,
    input  logic [H_W-1:0]  cfg_hs_in,
    input  logic [H_W-1:0]  cfg_hbp_in,
    input  logic [V_W-1:0]  cfg_va_in,
    input  logic [V_W-1:0]  cfg_vfp_in,
    input  logic [V_W-1:0]  cfg_vs_in,
    input  logic [V_W-1:0]  cfg_vbp_in,
    input  logic            cfg_hpol_in,
    input  logic            cfg_vpol_in,
    output logic [H_W-1:0]  hcount_out,
    output logic [V_W-1:0]  vcount_out,
    output logic            hs_out,
    output logic            vs_out,
    output logic            ad_out,
    output logic            nf_out,
    output logic [FC_W-1:0] fc_out,
    output logic            cfg_err_out
);

    typedef struct packed {
        logic [H_W-1:0] ha;
        logic [H_W-1:0] hfp;
        logic [H_W-1:0] hs;
        logic [H_W-1:0] hbp;
        logic [V_W-1:0] va;
        logic [V_W-1:0] vfp;
        logic [V_W-1:0] vs;
        logic [V_W-1:0] vbp;
        logic           hpol;
        logic           vpol;
    } timing_t;

    typedef enum logic {
        ST_IDLE,
        ST_PENDING
    } state_t;

    localparam timing_t DEF_TIMING = '{
        ha:   H_W'(DEF_HA),
        hfp:  H_W'(DEF_HFP),
        hs:   H_W'(DEF_HS),
        hbp:  H_W'(DEF_HBP),
        va:   V_W'(DEF_VA),
        vfp:  V_W'(DEF_VFP),
        vs:   V_W'(DEF_VS),
        vbp:  V_W'(DEF_VBP),
        hpol: DEF_HPOL,
        vpol: DEF_VPOL
    };

    localparam logic [H_W-1:0]  H_ONE   = H_W'(1);
    localparam logic [V_W-1:0]  V_ONE   = V_W'(1);
    localparam logic [FC_W-1:0] FC_ONE  = FC_W'(1);
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(FPS - 1);

    state_t         state_q, state_d;
    timing_t        act_q, act_d;
    timing_t        pend_q, pend_d;
    timing_t        cfg_in;
    logic [H_W-1:0] hcnt_q, hcnt_d;
    logic [V_W-1:0] vcnt_q, vcnt_d;
    logic [FC_W-1:0] fc_q, fc_d;
    logic           nf_q, nf_d;
    logic           err_q, err_d;

    logic [H_W-1:0] ht;
    logic [V_W-1:0] vt;
    logic [H_W-1:0] hs_start, hs_end;
    logic [V_W-1:0] vs_start, vs_end;
    logic           h_last, v_last, frame_wrap;
    logic           hs_raw, vs_raw;
    logic           cfg_xfer, cfg_bad;

    always_comb begin
        cfg_in      = '0;
        cfg_in.ha   = cfg_ha_in;
        cfg_in.hfp  = cfg_hfp_in;
        cfg_in.hs   = cfg_hs_in;
        cfg_in.hbp  = cfg_hbp_in;
        cfg_in.va   = cfg_va_in;
        cfg_in.vfp  = cfg_vfp_in;
        cfg_in.vs   = cfg_vs_in;
        cfg_in.vbp  = cfg_vbp_in;
        cfg_in.hpol = cfg_hpol_in;
        cfg_in.vpol = cfg_vpol_in;
    end

    // Totals fit the field width by construction of the timing sets, so no carry bit is kept.
    assign ht       = act_q.ha + act_q.hfp + act_q.hs + act_q.hbp;
    assign vt       = act_q.va + act_q.vfp + act_q.vs + act_q.vbp;
    assign hs_start = act_q.ha + act_q.hfp;
    assign hs_end   = hs_start + act_q.hs;
    assign vs_start = act_q.va + act_q.vfp;
    assign vs_end   = vs_start + act_q.vs;

    assign h_last     = (hcnt_q == ht - H_ONE);
    assign v_last     = (vcnt_q == vt - V_ONE);
    assign frame_wrap = h_last && v_last;

    assign hs_raw = (hcnt_q >= hs_start) && (hcnt_q < hs_end);
    assign vs_raw = (vcnt_q >= vs_start) && (vcnt_q < vs_end);

    // Ready is held low throughout reset, independent of the registered state.
    assign cfg_ready_out = (state_q == ST_IDLE) && !rst_in;
    assign cfg_xfer      = cfg_valid_in && cfg_ready_out;
    assign cfg_bad       = (cfg_ha_in == '0) || (cfg_hs_in == '0) ||
                           (cfg_va_in == '0) || (cfg_vs_in == '0);

    // Config FSM: a transfer lands in the pending set; it becomes active only on a
    // frame wrap seen while already PENDING, so a transfer on the wrap edge waits a frame.
    always_comb begin
        state_d = state_q;
        act_d   = act_q;
        pend_d  = pend_q;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cfg_xfer) begin
                    if (cfg_bad) begin
                        err_d = 1'b1;
                    end else begin
                        pend_d  = cfg_in;
                        state_d = ST_PENDING;
                    end
                end
            end
            ST_PENDING: begin
                if (frame_wrap) begin
                    act_d   = pend_q;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        hcnt_d = hcnt_q + H_ONE;
        vcnt_d = vcnt_q;
        if (h_last) begin
            hcnt_d = '0;
            vcnt_d = v_last ? '0 : vcnt_q + V_ONE;
        end
        // New frame is flagged on the last active pixel of the first blanking line.
        nf_d = (hcnt_q == act_q.ha - H_ONE) && (vcnt_q == act_q.va);
        fc_d = fc_q;
        if (nf_d) begin
            fc_d = (fc_q == FC_LAST) ? '0 : fc_q + FC_ONE;
        end
    end

    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            state_q <= ST_IDLE;
            act_q   <= DEF_TIMING;
            pend_q  <= '0;
            hcnt_q  <= '0;
            vcnt_q  <= '0;
            fc_q    <= '0;
            nf_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            act_q   <= act_d;
            pend_q  <= pend_d;
            hcnt_q  <= hcnt_d;
            vcnt_q  <= vcnt_d;
            fc_q    <= fc_d;
            nf_q    <= nf_d;
            err_q   <= err_d;
        end
    end

    assign hcount_out  = hcnt_q;
    assign vcount_out  = vcnt_q;
    assign hs_out      = act_q.hpol ? hs_raw : !hs_raw;
    assign vs_out      = act_q.vpol ? vs_raw : !vs_raw;
    assign ad_out      = (hcnt_q < act_q.ha) && (vcnt_q < act_q.va) && !rst_in;
    assign nf_out      = nf_q;
    assign fc_out      = fc_q;
    assign cfg_err_out = err_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen with small 16x8 raster (HT=16, VT=8, FPS=4).
module tb_video_timing_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [11:0] cfg_ha, cfg_hfp, cfg_hs, cfg_hbp;
    logic [10:0] cfg_va, cfg_vfp, cfg_vs, cfg_vbp;
    logic        cfg_hpol, cfg_vpol;
    logic [11:0] hcount;
    logic [10:0] vcount;
    logic        hs, vs, ad, nf, cfg_err;
    logic [5:0]  fc;

    always #5 clk = ~clk;

    video_timing_gen #(
        .H_W(12), .V_W(11), .FPS(4), .FC_W(6),
        .DEF_HA(8), .DEF_HFP(2), .DEF_HS(2), .DEF_HBP(4),
        .DEF_VA(4), .DEF_VFP(1), .DEF_VS(1), .DEF_VBP(2),
        .DEF_HPOL(1'b1), .DEF_VPOL(1'b1)
    ) dut (
        .pixel_clk_in (clk),
        .rst_in       (rst),
        .cfg_valid_in (cfg_valid),
        .cfg_ready_out(cfg_ready),
        .cfg_ha_in    (cfg_ha),
        .cfg_hfp_in   (cfg_hfp),
        .cfg_hs_in    (cfg_hs),
        .cfg_hbp_in   (cfg_hbp),
        .cfg_va_in    (cfg_va),
        .cfg_vfp_in   (cfg_vfp),
        .cfg_vs_in    (cfg_vs),
        .cfg_vbp_in   (cfg_vbp),
        .cfg_hpol_in  (cfg_hpol),
        .cfg_vpol_in  (cfg_vpol),
        .hcount_out   (hcount),
        .vcount_out   (vcount),
        .hs_out       (hs),
        .vs_out       (vs),
        .ad_out       (ad),
        .nf_out       (nf),
        .fc_out       (fc),
        .cfg_err_out  (cfg_err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Expected behaviour, advanced once per rising edge from the bench's own inputs.
    int e_ha, e_hfp, e_hs, e_hbp, e_va, e_vfp, e_vs, e_vbp, e_hpol, e_vpol;
    int p_ha, p_hfp, p_hs, p_hbp, p_va, p_vfp, p_vs, p_vbp, p_hpol, p_vpol;
    int e_pend, eh, ev, efc, enf, eerr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_defaults();
        e_ha = 8; e_hfp = 2; e_hs = 2; e_hbp = 4;
        e_va = 4; e_vfp = 1; e_vs = 1; e_vbp = 2;
        e_hpol = 1; e_vpol = 1;
    endtask

    task automatic clock_model();
        int ht, vt, wrap, xfer;
        if (rst) begin
            model_defaults();
            eh = 0; ev = 0; efc = 0; enf = 0; eerr = 0; e_pend = 0;
            return;
        end
        ht   = e_ha + e_hfp + e_hs + e_hbp;
        vt   = e_va + e_vfp + e_vs + e_vbp;
        wrap = (eh == ht - 1 && ev == vt - 1) ? 1 : 0;
        xfer = (cfg_valid && e_pend == 0) ? 1 : 0;
        enf  = (eh == e_ha - 1 && ev == e_va) ? 1 : 0;
        if (enf == 1) efc = (efc == 3) ? 0 : efc + 1;
        if (eh == ht - 1) begin
            eh = 0;
            ev = (ev == vt - 1) ? 0 : ev + 1;
        end else begin
            eh++;
        end
        eerr = 0;
        if (wrap == 1 && e_pend == 1) begin
            e_ha = p_ha; e_hfp = p_hfp; e_hs = p_hs; e_hbp = p_hbp;
            e_va = p_va; e_vfp = p_vfp; e_vs = p_vs; e_vbp = p_vbp;
            e_hpol = p_hpol; e_vpol = p_vpol;
            e_pend = 0;
        end
        if (xfer == 1) begin
            if (cfg_ha == 0 || cfg_hs == 0 || cfg_va == 0 || cfg_vs == 0) begin
                eerr = 1;
            end else begin
                p_ha = int'(cfg_ha); p_hfp = int'(cfg_hfp); p_hs = int'(cfg_hs); p_hbp = int'(cfg_hbp);
                p_va = int'(cfg_va); p_vfp = int'(cfg_vfp); p_vs = int'(cfg_vs); p_vbp = int'(cfg_vbp);
                p_hpol = int'(cfg_hpol); p_vpol = int'(cfg_vpol);
                e_pend = 1;
            end
        end
    endtask

    task automatic check_all(input string tag);
        bit hraw, vraw, e_hs_o, e_vs_o, e_ad, e_rdy;
        hraw   = (eh >= e_ha + e_hfp) && (eh < e_ha + e_hfp + e_hs);
        vraw   = (ev >= e_va + e_vfp) && (ev < e_va + e_vfp + e_vs);
        e_hs_o = (e_hpol == 1) ? hraw : !hraw;
        e_vs_o = (e_vpol == 1) ? vraw : !vraw;
        e_ad   = (eh < e_ha) && (ev < e_va) && !rst;
        e_rdy  = !rst && (e_pend == 0);
        chk({tag, ".hcount"}, 32'(hcount), eh);
        chk({tag, ".vcount"}, 32'(vcount), ev);
        chk({tag, ".hs"}, 32'(hs), 32'(e_hs_o));
        chk({tag, ".vs"}, 32'(vs), 32'(e_vs_o));
        chk({tag, ".ad"}, 32'(ad), 32'(e_ad));
        chk({tag, ".nf"}, 32'(nf), enf);
        chk({tag, ".fc"}, 32'(fc), efc);
        chk({tag, ".err"}, 32'(cfg_err), eerr);
        chk({tag, ".ready"}, 32'(cfg_ready), 32'(e_rdy));
    endtask

    task automatic step(input string tag);
        clock_model();
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic run_to(input int h, input int v, input string tag);
        int n = 0;
        while (!(eh == h && ev == v) && n < 400) begin
            step(tag);
            n++;
        end
        chk({tag, ".reach_h"}, 32'(hcount), h);
        chk({tag, ".reach_v"}, 32'(vcount), v);
    endtask

    task automatic wait_wrap(input string tag);
        int n = 0;
        while (e_pend == 1 && n < 300) begin
            step(tag);
            n++;
        end
        chk({tag, ".ready_back"}, 32'(cfg_ready), 1);
    endtask

    task automatic set_cfg(input int ha, input int hfp, input int hs_w, input int hbp,
                           input int va, input int vfp, input int vs_w, input int vbp,
                           input int hpol, input int vpol);
        cfg_ha = 12'(ha); cfg_hfp = 12'(hfp); cfg_hs = 12'(hs_w); cfg_hbp = 12'(hbp);
        cfg_va = 11'(va); cfg_vfp = 11'(vfp); cfg_vs = 11'(vs_w); cfg_vbp = 11'(vbp);
        cfg_hpol = hpol[0]; cfg_vpol = vpol[0];
    endtask

    initial begin
        logic [5:0] fc_starts [$];
        int         nf_seen;
        int         exp_fc [5] = '{0, 1, 2, 3, 0};

        rst = 1'b1;
        cfg_valid = 1'b0;
        set_cfg(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        model_defaults();
        eh = 0; ev = 0; efc = 0; enf = 0; eerr = 0; e_pend = 0;

        // Reset: everything zero, ready low.
        repeat (3) step("reset");

        // Release: ready high immediately, counting from 0,0.
        rst = 1'b0;
        #1;
        check_all("release");

        // Free run for five frames of 128 cycles.
        nf_seen = 0;
        fc_starts.push_back(fc);
        for (int k = 1; k <= 640; k++) begin
            step("free");
            if (nf) begin
                nf_seen++;
                chk("free.nf_at_h", 32'(hcount), 8);
                chk("free.nf_at_v", 32'(vcount), 4);
            end
            if (eh == 0 && ev == 0) fc_starts.push_back(fc);
        end
        chk("free.nf_count", nf_seen, 5);
        chk("free.frames", fc_starts.size(), 6);
        for (int i = 0; i < 5; i++) chk($sformatf("free.fc_frame%0d", i), 32'(fc_starts[i]), exp_fc[i]);

        // Shrink HA to 4, offered mid-frame at hcount=3, vcount=1.
        run_to(3, 1, "ha4_nav");
        set_cfg(4, 2, 2, 4, 4, 1, 1, 2, 1, 1);
        cfg_valid = 1'b1;
        step("ha4_xfer");
        cfg_valid = 1'b0;
        chk("ha4.ready_low", 32'(cfg_ready), 0);
        wait_wrap("ha4_wait");
        chk("ha4.at_wrap_h", 32'(hcount), 0);
        repeat (3) step("ha4_frame");
        chk("ha4.ad_h3", 32'(ad), 1);
        step("ha4_frame");
        chk("ha4.ad_h4", 32'(ad), 0);
        repeat (8) step("ha4_frame");
        chk("ha4.ht12_h", 32'(hcount), 0);
        chk("ha4.ht12_v", 32'(vcount), 1);

        // Back to HA=8 with active-low hsync.
        set_cfg(8, 2, 2, 4, 4, 1, 1, 2, 0, 1);
        cfg_valid = 1'b1;
        step("pol_xfer");
        cfg_valid = 1'b0;
        wait_wrap("pol_wait");
        run_to(9, 2, "pol_nav");
        chk("pol.hs_h9", 32'(hs), 1);
        step("pol");
        chk("pol.hs_h10", 32'(hs), 0);
        step("pol");
        chk("pol.hs_h11", 32'(hs), 0);
        step("pol");
        chk("pol.hs_h12", 32'(hs), 1);
        run_to(0, 5, "pol_vnav");
        chk("pol.vs_v5", 32'(vs), 1);

        // Rejected set: VS=0.
        set_cfg(8, 2, 2, 4, 4, 1, 0, 2, 0, 1);
        cfg_valid = 1'b1;
        step("rej_xfer");
        cfg_valid = 1'b0;
        chk("rej.err_pulse", 32'(cfg_err), 1);
        chk("rej.ready_high", 32'(cfg_ready), 1);
        step("rej");
        chk("rej.err_clear", 32'(cfg_err), 0);
        repeat (128) step("rej_frame");

        // Transfer on the frame-wrap edge itself: applies one frame later.
        run_to(15, 7, "wrapx_nav");
        set_cfg(6, 2, 2, 4, 4, 1, 1, 2, 1, 1);
        cfg_valid = 1'b1;
        step("wrapx_xfer");
        cfg_valid = 1'b0;
        chk("wrapx.h0", 32'(hcount), 0);
        chk("wrapx.v0", 32'(vcount), 0);
        chk("wrapx.ready_low", 32'(cfg_ready), 0);
        repeat (16) step("wrapx_old");
        chk("wrapx.old_ht_h", 32'(hcount), 0);
        chk("wrapx.old_ht_v", 32'(vcount), 1);
        wait_wrap("wrapx_wait");
        repeat (14) step("wrapx_new");
        chk("wrapx.new_ht_h", 32'(hcount), 0);
        chk("wrapx.new_ht_v", 32'(vcount), 1);

        // Reset while PENDING at hcount=9, vcount=6.
        set_cfg(5, 2, 2, 4, 4, 1, 1, 2, 1, 1);
        cfg_valid = 1'b1;
        step("rst_xfer");
        cfg_valid = 1'b0;
        chk("rst.pending", 32'(cfg_ready), 0);
        run_to(9, 6, "rst_nav");
        rst = 1'b1;
        step("rst_hold");
        chk("rst.h", 32'(hcount), 0);
        chk("rst.v", 32'(vcount), 0);
        chk("rst.nf", 32'(nf), 0);
        chk("rst.fc", 32'(fc), 0);
        chk("rst.err", 32'(cfg_err), 0);
        chk("rst.ready", 32'(cfg_ready), 0);
        chk("rst.ad", 32'(ad), 0);
        step("rst_hold");
        rst = 1'b0;
        #1;
        chk("rst.ready_release", 32'(cfg_ready), 1);
        check_all("rst_release");
        repeat (16) step("rst_def");
        chk("rst.def_ht_h", 32'(hcount), 0);
        chk("rst.def_ht_v", 32'(vcount), 1);
        repeat (200) step("rst_after");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
